overlay_writer: RTL and testbench
=================================

# overlay_writer

Write side of the overlay picture path: takes the HPS ioctl byte stream for the overlay file (index 2), packs byte pairs into 16-bit RBGA words (4 bits per channel), and writes them to SDRAM through a buffered request/acknowledge handshake. It back-pressures the HPS with `ioctl_wait`. Once a complete overlay is stored, it raises `use_bg` for the pixel fetcher that reads the overlay back during active video.

## Interface
- `ADDR_W`, 25: byte address width of the ioctl and memory buses.
- `FIFO_DEPTH`, 4: word buffer entries; power of two, minimum 2.
- `OVR_INDEX`, 8'd2: `ioctl_index` value selecting the overlay file.

- `clk_sys`  in  1: system clock; all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ioctl_download`  in  1: download in progress.
- `ioctl_index`  in  8: file index of the current download.
- `ioctl_wr`  in  1: single-cycle byte strobe.
- `ioctl_addr`  in  ADDR_W: byte address.
- `ioctl_dout`  in  8: byte data.
- `ioctl_wait`  out  1: stall request to the HPS.
- `sdram_present`  in  1: nonzero SDRAM size reported by HPS.
- `mem_addr`  out  ADDR_W: word byte-address, bit 0 always 0.
- `mem_din`  out  16: write data.
- `mem_we`  out  1: write request, held until acknowledged.
- `mem_ready`  in  1: write accepted in this cycle.
- `use_bg`  out  1: overlay valid in SDRAM.
- `done`  out  1: one-cycle pulse when a download is fully committed.

## Operation
- Active download (`act`): `ioctl_download & (ioctl_index == OVR_INDEX)`.
- States:
  - IDLE to LOAD on the rising edge of `act`. Entering LOAD clears `use_bg`, the FIFO, the pair latch and the word counter.
  - LOAD to FLUSH when `act` falls.
  - FLUSH to DONE when the pair latch is empty, the FIFO is empty and `mem_we` is low.
  - DONE to IDLE after one cycle. `done` is asserted in DONE.
  - In DONE, `use_bg <= sdram_present & (word counter != 0)`.
- Pair latch holds one even byte, its address and a valid flag.
  - Even-address byte with the latch empty: store it in the latch.
  - Even-address byte with the latch full: first push `{8'h00, latched}`, then store the new byte.
  - Odd-address byte at latched address + 1: push `{byte, latched}` at the latched address and clear the latch.
  - Odd-address byte otherwise: push `{byte, 8'h00}` at the address with bit 0 cleared. The latch is not affected.
  - At most one push per cycle. The even-byte-with-latch-full case therefore occupies one push; the new byte only fills the latch.
- FLUSH with the latch full: push `{8'h00, latched}` once, then clear the latch.
- FIFO holds entries of `{addr, data}`. The head drives `mem_addr`/`mem_din` through registers. `mem_we` is high whenever the head is valid.
  - Pop on `mem_we & mem_ready`, then increment the 24-bit saturating word counter.
  - `mem_addr`/`mem_din` must not change while `mem_we` is high and unacknowledged.
- `ioctl_wait` is combinational from FIFO count: high when count ≥ FIFO_DEPTH−1. This guarantees room for the at most one byte already in flight.
- Writes while not `act` are ignored.
- A rising `act` seen in FLUSH is held pending. LOAD restarts from DONE on the next cycle.

## Timing
- Reset values:
  - Outputs: `ioctl_wait` 0, `mem_we` 0, `mem_addr` 0, `mem_din` 0, `use_bg` 0, `done` 0.
  - Internal: state IDLE, FIFO empty, latch invalid, counter 0.
- Latency with an empty FIFO: odd byte strobe at cycle N, FIFO push at N+1, `mem_we` high at N+2.
- Throughput: one word per cycle when `mem_ready` is tied high.
- Full FIFO: a push in the same cycle as a pop is accepted. A push into a full FIFO with no pop is a design error; flag it with an assertion.
- `done` asserts 2 cycles after the final acknowledge if no flush word is pending.
- Reset mid-operation: the write is abandoned immediately, `mem_we` drops asynchronously, and `use_bg` stays 0 until the next complete download.

## Test plan
- Download of 8 sequential bytes 00..07 at address 0 with `mem_ready` tied high:
  - writes (0, 16'h0100), (2, 16'h0302), (4, 16'h0504), (6, 16'h0706);
  - `done` pulses once;
  - `use_bg` = 1 when `sdram_present` = 1.
- Same download with `sdram_present` = 0: four writes, `done` pulses, `use_bg` stays 0.
- `mem_ready` held low for 20 cycles during a 16-byte burst:
  - `ioctl_wait` rises when count reaches 3;
  - no word is lost or duplicated;
  - `mem_addr`/`mem_din` are stable while `mem_we` is high.
- Odd-length download of 3 bytes AA, BB, CC: writes (0, 16'hBBAA) then (2, 16'h00CC) from FLUSH.
- Out-of-order bytes (odd byte 0x55 at address 5 first): write (4, 16'h5500).
- `reset_n` pulsed low mid-burst:
  - `mem_we` goes 0 immediately and `use_bg` = 0;
  - a following clean 4-byte download gives two writes and `use_bg` = 1.

Source files
------------

// File: rtl/overlay_writer.sv
// Packs overlay-file ioctl bytes into 16-bit RBGA words and writes them to SDRAM; raises use_bg once a full overlay is stored.
// Latency: odd byte strobe at N -> FIFO push at N+1 -> mem_we at N+2; one word per cycle when mem_ready stays high.
// Backpressure: ioctl_wait is high while the word FIFO holds FIFO_DEPTH-1 or more entries; mem_we holds its word until mem_ready.
// Ports: clk_sys/reset_n (async active-low); ioctl_* HPS download stream in, ioctl_wait out;
//        mem_addr/mem_din/mem_we out with mem_ready in (request/acknowledge write port);
//        sdram_present in; use_bg (overlay valid) and done (one-cycle commit pulse) out.
module overlay_writer #(
   parameter int         ADDR_W     = 25,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] OVR_INDEX  = 8'd2
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic              sdram_present,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              use_bg,
   output logic              done
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t            state_q;
   logic              act, act_q, act_rise, pend_q;
   logic              use_bg_q, done_q;
   logic              wr_byte, odd_pair, pop, flush_ok, enter_load;

   // Pair latch: holds an even byte until its odd partner arrives.
   logic              lat_vld_q, lat_vld_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [7:0]        lat_dat_q, lat_dat_d;

   // One-cycle push stage in front of the FIFO; it commits every cycle.
   logic              push_vld_q, push_vld_d;
   logic [ADDR_W-1:0] push_addr_q, push_addr_d;
   logic [15:0]       push_dat_q, push_dat_d;

   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [15:0]       fifo_dat_q  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [23:0]       wcnt_q;

   assign act        = ioctl_download & (ioctl_index == OVR_INDEX);
   assign act_rise   = act & ~act_q;
   assign wr_byte    = ioctl_wr & act & (state_q == S_LOAD);
   assign odd_pair   = lat_vld_q & (ioctl_addr == lat_addr_q + ADDR_W'(1));
   assign pop        = mem_we & mem_ready;
   assign flush_ok   = ~lat_vld_q & ~push_vld_q & (cnt_q == '0);
   assign enter_load = ((state_q == S_IDLE) & act_rise) |
                       ((state_q == S_DONE) & (pend_q | act_rise));

   // Head entry is read straight from the storage registers; it only moves on a pop,
   // so address/data stay put while a request is outstanding.
   assign mem_we     = (cnt_q != '0);
   assign mem_addr   = fifo_addr_q[rd_ptr_q];
   assign mem_din    = fifo_dat_q[rd_ptr_q];
   // Threshold one below full leaves room for the single byte already past the stall.
   assign ioctl_wait = (cnt_q >= CNT_W'(FIFO_DEPTH - 1));
   assign use_bg     = use_bg_q;
   assign done       = done_q;

   always_comb begin
      push_vld_d  = 1'b0;
      push_addr_d = lat_addr_q;
      push_dat_d  = {8'h00, lat_dat_q};
      lat_vld_d   = lat_vld_q;
      lat_addr_d  = lat_addr_q;
      lat_dat_d   = lat_dat_q;
      if (wr_byte) begin
         if (!ioctl_addr[0]) begin
            // An orphaned even byte is written out alone before the new one is latched.
            push_vld_d = lat_vld_q;
            lat_vld_d  = 1'b1;
            lat_addr_d = ioctl_addr;
            lat_dat_d  = ioctl_dout;
         end else if (odd_pair) begin
            push_vld_d = 1'b1;
            push_dat_d = {ioctl_dout, lat_dat_q};
            lat_vld_d  = 1'b0;
         end else begin
            // Unpaired odd byte: written with a zero low byte, latch left alone.
            push_vld_d  = 1'b1;
            push_addr_d = {ioctl_addr[ADDR_W-1:1], 1'b0};
            push_dat_d  = {ioctl_dout, 8'h00};
         end
      end else if ((state_q == S_FLUSH) && lat_vld_q) begin
         push_vld_d = 1'b1;
         lat_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         lat_vld_q   <= 1'b0;
         lat_addr_q  <= '0;
         lat_dat_q   <= '0;
         push_vld_q  <= 1'b0;
         push_addr_q <= '0;
         push_dat_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_dat_q[i]  <= '0;
         end
      end else if (enter_load) begin
         lat_vld_q  <= 1'b0;
         push_vld_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         wcnt_q     <= '0;
      end else begin
         lat_vld_q   <= lat_vld_d;
         lat_addr_q  <= lat_addr_d;
         lat_dat_q   <= lat_dat_d;
         push_vld_q  <= push_vld_d;
         push_addr_q <= push_addr_d;
         push_dat_q  <= push_dat_d;
         if (push_vld_q) begin
            fifo_addr_q[wr_ptr_q] <= push_addr_q;
            fifo_dat_q[wr_ptr_q]  <= push_dat_q;
            wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wcnt_q != '1) wcnt_q <= wcnt_q + 24'd1;
         end
         if (push_vld_q && !pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (!push_vld_q && pop) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         act_q    <= 1'b0;
         pend_q   <= 1'b0;
         use_bg_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         act_q  <= act;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (act_rise) begin
                  state_q  <= S_LOAD;
                  use_bg_q <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!act) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               // A new download starting during the flush is remembered and started after DONE.
               if (act_rise) pend_q <= 1'b1;
               if (flush_ok) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               if (pend_q || act_rise) begin
                  state_q  <= S_LOAD;
                  pend_q   <= 1'b0;
                  use_bg_q <= 1'b0;
               end else begin
                  state_q  <= S_IDLE;
                  use_bg_q <= sdram_present & (wcnt_q != '0);
               end
            end
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_sys) disable iff (!reset_n)
      !(push_vld_q && !pop && (cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_overlay_writer.sv
module tb_overlay_writer;
   localparam int ADDR_W = 25;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              ioctl_download = 1'b0;
   logic [7:0]        ioctl_index = 8'd2;
   logic              ioctl_wr = 1'b0;
   logic [ADDR_W-1:0] ioctl_addr = '0;
   logic [7:0]        ioctl_dout = '0;
   logic              ioctl_wait;
   logic              sdram_present = 1'b1;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic              mem_we;
   logic              mem_ready = 1'b1;
   logic              use_bg;
   logic              done;

   overlay_writer dut (
      .clk_sys(clk), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wait(ioctl_wait), .sdram_present(sdram_present),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_ready(mem_ready), .use_bg(use_bg), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       nb;
      logic [7:0][7:0]  ba;
      logic [7:0][7:0]  bd;
      logic             sdram;
      logic [2:0]       nw;
      logic [3:0][7:0]  wa;
      logic [3:0][15:0] wd;
      logic             ubg;
   } vec_t;

   vec_t        vecs [8];
   int          nvec = 0;
   int          nfail = 0;
   int          done_cnt = 0;
   logic [40:0] cap [$];
   logic        hold_vld = 1'b0;
   logic [40:0] hold_val = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write capture, done counting and hold-stability of the request while stalled.
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_vld <= 1'b0;
      end else begin
         if (hold_vld) begin
            check("hold_we", 64'(mem_we), 64'd1);
            check("hold_addr_din", 64'({mem_addr, mem_din}), 64'(hold_val));
         end
         hold_vld <= mem_we & ~mem_ready;
         hold_val <= {mem_addr, mem_din};
         if (mem_we && mem_ready) cap.push_back({mem_addr, mem_din});
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      int guard = 0;
      while (ioctl_wait && guard < 200) begin
         cycles(1);
         guard++;
      end
      if (guard >= 200) begin
         nvec++;
         nfail++;
         $display("FAIL send_timeout: ioctl_wait still %0b, required 0", ioctl_wait);
      end
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      cycles(1);
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      cycles(2);
   endtask

   task automatic end_dl(input int d0);
      int guard = 0;
      ioctl_download = 1'b0;
      while (done_cnt == d0 && guard < 100) begin
         cycles(1);
         guard++;
      end
      if (guard >= 100) begin
         nvec++;
         nfail++;
         $display("FAIL done_timeout: done pulses %0d, required 1", done_cnt - d0);
      end
      cycles(3);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int d0 = done_cnt;
      cap.delete();
      sdram_present = v.sdram;
      mem_ready     = 1'b1;
      start_dl();
      for (int i = 0; i < int'(v.nb); i++) send(ADDR_W'(v.ba[i]), v.bd[i]);
      end_dl(d0);
      check($sformatf("v%0d_nwords", id), 64'(cap.size()), 64'(v.nw));
      for (int i = 0; i < int'(v.nw); i++) begin
         if (i < cap.size())
            check($sformatf("v%0d_word%0d", id, i), 64'(cap[i]), 64'({17'd0, v.wa[i], v.wd[i]}));
      end
      check($sformatf("v%0d_done", id), 64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d_use_bg", id), 64'(use_bg), 64'(v.ubg));
   endtask

   task automatic setb(input int v, input int k, input logic [7:0] a, input logic [7:0] d);
      vecs[v].ba[k] = a;
      vecs[v].bd[k] = d;
   endtask

   task automatic setw(input int v, input int k, input logic [7:0] a, input logic [15:0] d);
      vecs[v].wa[k] = a;
      vecs[v].wd[k] = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      for (int i = 0; i < 8; i++) vecs[i] = '0;
      // 0: sequential bytes 00..07, SDRAM present
      vecs[0].nb = 4'd8; vecs[0].sdram = 1'b1; vecs[0].nw = 3'd4; vecs[0].ubg = 1'b1;
      for (int k = 0; k < 8; k++) setb(0, k, 8'(k), 8'(k));
      setw(0, 0, 8'd0, 16'h0100); setw(0, 1, 8'd2, 16'h0302);
      setw(0, 2, 8'd4, 16'h0504); setw(0, 3, 8'd6, 16'h0706);
      // 1: same download without SDRAM
      vecs[1] = vecs[0]; vecs[1].sdram = 1'b0; vecs[1].ubg = 1'b0;
      // 2: odd length, last byte flushed alone
      vecs[2].nb = 4'd3; vecs[2].sdram = 1'b1; vecs[2].nw = 3'd2; vecs[2].ubg = 1'b1;
      setb(2, 0, 8'd0, 8'hAA); setb(2, 1, 8'd1, 8'hBB); setb(2, 2, 8'd2, 8'hCC);
      setw(2, 0, 8'd0, 16'hBBAA); setw(2, 1, 8'd2, 16'h00CC);
      // 3: lone odd byte
      vecs[3].nb = 4'd1; vecs[3].sdram = 1'b1; vecs[3].nw = 3'd1; vecs[3].ubg = 1'b1;
      setb(3, 0, 8'd5, 8'h55); setw(3, 0, 8'd4, 16'h5500);
      // 4: even byte arriving while latch is full
      vecs[4].nb = 4'd3; vecs[4].sdram = 1'b1; vecs[4].nw = 3'd2; vecs[4].ubg = 1'b1;
      setb(4, 0, 8'd0, 8'h11); setb(4, 1, 8'd2, 8'h22); setb(4, 2, 8'd3, 8'h33);
      setw(4, 0, 8'd0, 16'h0011); setw(4, 1, 8'd2, 16'h3322);
      // 5: non-matching odd byte leaves the latch intact
      vecs[5].nb = 4'd3; vecs[5].sdram = 1'b1; vecs[5].nw = 3'd2; vecs[5].ubg = 1'b1;
      setb(5, 0, 8'd0, 8'h11); setb(5, 1, 8'd7, 8'h99); setb(5, 2, 8'd1, 8'h22);
      setw(5, 0, 8'd6, 16'h9900); setw(5, 1, 8'd0, 16'h2211);
      // 6: empty download -> no words, overlay not valid
      vecs[6].sdram = 1'b1;
      // 7: clean 4-byte download after a reset
      vecs[7].nb = 4'd4; vecs[7].sdram = 1'b1; vecs[7].nw = 3'd2; vecs[7].ubg = 1'b1;
      for (int k = 0; k < 4; k++) setb(7, k, 8'(k), 8'hA0 + 8'(k));
      setw(7, 0, 8'd0, 16'hA1A0); setw(7, 1, 8'd2, 16'hA3A2);

      #2 reset_n = 1'b0;
      #1;
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_din", 64'(mem_din), 64'd0);
      check("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
      check("rst_use_bg", 64'(use_bg), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      cycles(3);
      reset_n = 1'b1;
      cycles(2);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Latency and done timing with an empty FIFO.
      cap.delete(); d0 = done_cnt; sdram_present = 1'b1; mem_ready = 1'b1;
      start_dl();
      send(25'd0, 8'h12);
      send(25'd1, 8'h34);
      check("lat_n1_we", 64'(mem_we), 64'd0);
      cycles(1);
      check("lat_n2_we", 64'(mem_we), 64'd1);
      check("lat_n2_word", 64'({mem_addr, mem_din}), 64'({25'd0, 16'h3412}));
      ioctl_download = 1'b0;
      cycles(1);
      check("lat_done_early", 64'(done), 64'd0);
      cycles(1);
      check("lat_done", 64'(done), 64'd1);
      cycles(3);
      check("lat_nwords", 64'(cap.size()), 64'd1);
      check("lat_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("lat_use_bg", 64'(use_bg), 64'd1);

      // Stalled memory during a 16-byte burst.
      cap.delete(); d0 = done_cnt; mem_ready = 1'b0;
      start_dl();
      for (int k = 0; k < 4; k++) send(ADDR_W'(k), 8'h40 + 8'(k));
      cycles(3);
      check("bp_wait_cnt2", 64'(ioctl_wait), 64'd0);
      for (int k = 4; k < 6; k++) send(ADDR_W'(k), 8'h40 + 8'(k));
      cycles(3);
      check("bp_wait_cnt3", 64'(ioctl_wait), 64'd1);
      check("bp_we_held", 64'(mem_we), 64'd1);
      fork
         begin
            for (int k = 6; k < 16; k++) send(ADDR_W'(k), 8'h40 + 8'(k));
         end
         begin
            cycles(14);
            mem_ready = 1'b1;
         end
      join
      end_dl(d0);
      check("bp_nwords", 64'(cap.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < cap.size())
            check($sformatf("bp_word%0d", k), 64'(cap[k]),
                  64'({ADDR_W'(2 * k), 8'h40 + 8'(2 * k + 1), 8'h40 + 8'(2 * k)}));
      end
      check("bp_done", 64'(done_cnt - d0), 64'd1);

      // A download of another file index is ignored.
      cap.delete(); d0 = done_cnt; ioctl_index = 8'd3;
      start_dl();
      send(25'd0, 8'h77);
      send(25'd1, 8'h88);
      ioctl_download = 1'b0;
      cycles(10);
      check("idx_nwords", 64'(cap.size()), 64'd0);
      check("idx_done", 64'(done_cnt - d0), 64'd0);
      check("idx_use_bg", 64'(use_bg), 64'd1);
      ioctl_index = 8'd2;

      // Reset in the middle of a stalled burst.
      cap.delete(); mem_ready = 1'b0;
      start_dl();
      for (int k = 0; k < 4; k++) send(ADDR_W'(k), 8'h60 + 8'(k));
      cycles(3);
      check("mid_we_before", 64'(mem_we), 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_we_rst", 64'(mem_we), 64'd0);
      check("mid_use_bg_rst", 64'(use_bg), 64'd0);
      ioctl_download = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(2);
      check("mid_use_bg_after", 64'(use_bg), 64'd0);
      run_vec(vecs[7], 7);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
